line_clear_engine: RTL and testbench

- Sits downstream of the game executioner. It consumes the fixed board captured when the active piece locks, then finds and removes full rows, collapsing the rows above each one down by one.
- Returns the compacted board and asserts clearing_line while busy; the executioner uses this to flush gravity.
- Keeps line and score statistics.
- Scans and shifts one row per cycle in the game_clk domain.

---
 rtl/game_state_pkg.sv | 44 ++++
 rtl/row_full_detector.sv | 20 ++
 rtl/line_clear_engine.sv | 114 +++++++++++
 tb/tb_line_clear_engine.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_state_pkg.sv
// rtl/game_state_pkg.sv - board types, FSM states and score table shared by the line clear engine
package game_state_pkg;

  localparam int ROWS_DEFAULT = 20;
  localparam int COLS_DEFAULT = 10;

  typedef logic [2:0] cell_t;
  localparam cell_t CELL_EMPTY = 3'd0;

  typedef cell_t [0:COLS_DEFAULT-1] row_t;

  // screen[0] is the top row
  typedef struct packed {
    row_t [0:ROWS_DEFAULT-1] screen;
  } game_state_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    SHIFT,
    DONE
  } line_clear_state_t;

  localparam logic [23:0] SCORE_TABLE [0:4] = '{24'd0, 24'd40, 24'd100, 24'd300, 24'd1200};

  function automatic row_t blank_row();
    row_t row;
    for (int c = 0; c < COLS_DEFAULT; c++) begin
      row[c] = CELL_EMPTY;
    end
    return row;
  endfunction

  function automatic game_state_t make_blank_game_state();
    game_state_t gs;
    for (int r = 0; r < ROWS_DEFAULT; r++) begin
      gs.screen[r] = blank_row();
    end
    return gs;
  endfunction

  localparam game_state_t blank_game_state = make_blank_game_state();

endpackage

// File: rtl/row_full_detector.sv
// rtl/row_full_detector.sv - flags a row whose every cell is occupied
module row_full_detector
  import game_state_pkg::*;
#(
  parameter int COLS = COLS_DEFAULT
) (
  input  cell_t [0:COLS-1] row,
  output logic             full
);

  always_comb begin
    full = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (row[c] == CELL_EMPTY) begin
        full = 1'b0;
      end
    end
  end

endmodule

// File: rtl/line_clear_engine.sv
// rtl/line_clear_engine.sv - removes full rows one per cycle and keeps line/score stats (score gated by LINE_CLEAR_SCORE_EN)
module line_clear_engine
  import game_state_pkg::*;
#(
  parameter int ROWS    = ROWS_DEFAULT,
  parameter int COLS    = COLS_DEFAULT,
  parameter int TOTAL_W = 16
) (
  input  logic               game_clk,
  input  logic               reset,
  input  logic               lock_valid,
  input  game_state_t        board_in,
  output game_state_t        board_out,
  output logic               board_out_valid,
  output logic               clearing_line,
  output logic [4:0]         last_clear,
  output logic [TOTAL_W-1:0] lines_total,
  output logic               lock_dropped,
  output logic [23:0]        score
);

  line_clear_state_t state;
  game_state_t       work;
  logic [4:0]        r;
  logic [4:0]        k;
  logic              row_full;
  logic [TOTAL_W:0]  lines_sum;

  row_full_detector #(
    .COLS(COLS)
  ) u_row_full_detector (
    .row (work.screen[r]),
    .full(row_full)
  );

  assign clearing_line = (state != IDLE);
  assign lines_sum     = {1'b0, lines_total} + {{(TOTAL_W-4){1'b0}}, k};

  always_ff @(posedge game_clk) begin
    if (reset) begin
      state           <= IDLE;
      work            <= blank_game_state;
      r               <= 5'd0;
      k               <= 5'd0;
      board_out       <= blank_game_state;
      board_out_valid <= 1'b0;
      last_clear      <= 5'd0;
      lines_total     <= '0;
      lock_dropped    <= 1'b0;
    end else begin
      board_out_valid <= 1'b0;
      if (lock_valid && state != IDLE) begin
        lock_dropped <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (lock_valid) begin
            work  <= board_in;
            r     <= 5'(ROWS - 1);
            k     <= 5'd0;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (row_full) begin
            state <= SHIFT;
          end else if (r == 5'd0) begin
            state <= DONE;
          end else begin
            r <= r - 5'd1;
          end
        end
        SHIFT: begin
          // Collapse everything above r by one; r is rescanned since the row dropped into it may be full too
          for (int i = 1; i < ROWS; i++) begin
            if (i <= int'(r)) begin
              work.screen[i] <= work.screen[i-1];
            end
          end
          work.screen[0] <= blank_row();
          k              <= k + 5'd1;
          state          <= SCAN;
        end
        DONE: begin
          board_out       <= work;
          board_out_valid <= 1'b1;
          last_clear      <= k;
          lines_total     <= lines_sum[TOTAL_W] ? '1 : lines_sum[TOTAL_W-1:0];
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LINE_CLEAR_SCORE_EN
  logic [2:0]  score_idx;
  logic [24:0] score_sum;

  assign score_idx = (k > 5'd4) ? 3'd4 : k[2:0];
  assign score_sum = {1'b0, score} + {1'b0, SCORE_TABLE[score_idx]};

  always_ff @(posedge game_clk) begin
    if (reset) begin
      score <= 24'd0;
    end else if (state == DONE) begin
      score <= score_sum[24] ? 24'hFFFFFF : score_sum[23:0];
    end
  end
`else
  assign score = 24'd0;
`endif

endmodule

// File: tb/tb_line_clear_engine.sv
// tb/tb_line_clear_engine.sv - scoreboard bench for line_clear_engine against a row-compaction model
module tb_line_clear_engine;
  import game_state_pkg::*;

  localparam int ROWS    = ROWS_DEFAULT;
  localparam int COLS    = COLS_DEFAULT;
  localparam int TOTAL_W = 16;

  logic               game_clk = 1'b0;
  logic               reset = 1'b1;
  logic               lock_valid = 1'b0;
  game_state_t        board_in = blank_game_state;
  game_state_t        board_out;
  logic               board_out_valid;
  logic               clearing_line;
  logic [4:0]         last_clear;
  logic [TOTAL_W-1:0] lines_total;
  logic               lock_dropped;
  logic [23:0]        score;

  line_clear_engine #(
    .ROWS(ROWS), .COLS(COLS), .TOTAL_W(TOTAL_W)
  ) dut (
    .game_clk       (game_clk),
    .reset          (reset),
    .lock_valid     (lock_valid),
    .board_in       (board_in),
    .board_out      (board_out),
    .board_out_valid(board_out_valid),
    .clearing_line  (clearing_line),
    .last_clear     (last_clear),
    .lines_total    (lines_total),
    .lock_dropped   (lock_dropped),
    .score          (score)
  );

  always #5 game_clk = ~game_clk;

  int cyc = 0;
  always @(posedge game_clk) cyc++;

  typedef struct {
    game_state_t        board;
    int                 k;
    logic [TOTAL_W-1:0] lines;
    logic [23:0]        score;
    int                 lock_cyc;
  } exp_t;

  exp_t               sb[$];
  exp_t               mon_e;
  int                 vectors = 0;
  int                 miscompares = 0;
  int                 busy = 0;
  logic [TOTAL_W-1:0] m_lines = '0;
  logic [23:0]        m_score = '0;
  int                 pts[5] = '{0, 40, 100, 300, 1200};

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_board(input string name, input game_state_t act, input game_state_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: keep non-full rows bottom-up in order, pad the top with empty rows
  function automatic game_state_t ref_clear(input game_state_t b, output int k);
    game_state_t o = blank_game_state;
    int dst = ROWS - 1;
    k = 0;
    for (int rr = ROWS - 1; rr >= 0; rr--) begin
      bit full = 1'b1;
      for (int c = 0; c < COLS; c++) if (b.screen[rr][c] == CELL_EMPTY) full = 1'b0;
      if (full) k++;
      else begin
        o.screen[dst] = b.screen[rr];
        dst--;
      end
    end
    return o;
  endfunction

  function automatic game_state_t with_row(input game_state_t b, input int rr, input logic [9:0] pat);
    game_state_t o = b;
    for (int c = 0; c < COLS; c++) o.screen[rr][c] = pat[c] ? cell_t'((rr + c) % 7 + 1) : CELL_EMPTY;
    return o;
  endfunction

  function automatic game_state_t rand_board();
    game_state_t o = blank_game_state;
    for (int rr = 0; rr < ROWS; rr++) begin
      logic [9:0] pat;
      if ($urandom_range(3) == 0) pat = 10'h3FF;
      else begin
        pat = 10'($urandom);
        pat[$urandom_range(COLS - 1)] = 1'b0;
      end
      o = with_row(o, rr, pat);
    end
    return o;
  endfunction

  task automatic issue(input game_state_t b);
    exp_t   e;
    int     kk;
    longint t;
    @(negedge game_clk);
    board_in   = b;
    lock_valid = 1'b1;
    e.board    = ref_clear(b, kk);
    e.k        = kk;
    t          = longint'(m_lines) + kk;
    m_lines    = (t > (2 ** TOTAL_W) - 1) ? '1 : TOTAL_W'(t);
`ifdef LINE_CLEAR_SCORE_EN
    t          = longint'(m_score) + pts[(kk > 4) ? 4 : kk];
    m_score    = (t > 24'hFFFFFF) ? 24'hFFFFFF : 24'(t);
`endif
    e.lines    = m_lines;
    e.score    = m_score;
    e.lock_cyc = cyc;
    sb.push_back(e);
    @(negedge game_clk);
    lock_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge game_clk);
      n++;
    end
    check("drain_timeout", sb.size(), 0);
    @(negedge game_clk);
  endtask

  task automatic check_reset_values();
    check_board("rst_board_out", board_out, blank_game_state);
    check("rst_valid", board_out_valid, 0);
    check("rst_clearing_line", clearing_line, 0);
    check("rst_last_clear", last_clear, 0);
    check("rst_lines_total", lines_total, 0);
    check("rst_lock_dropped", lock_dropped, 0);
    check("rst_score", score, 0);
  endtask

  always @(negedge game_clk) begin
    if (reset) begin
      busy = 0;
    end else begin
      if (clearing_line) busy++;
      if (board_out_valid) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_valid: got pulse at cycle %0d expected none", cyc);
        end else begin
          mon_e = sb.pop_front();
          check("latency", cyc - mon_e.lock_cyc, ROWS + 2 * mon_e.k + 2);
          check("clearing_cycles", busy, ROWS + 2 * mon_e.k + 1);
          check_board("board_out", board_out, mon_e.board);
          check("last_clear", last_clear, mon_e.k);
          check("lines_total", lines_total, mon_e.lines);
          check("score", score, mon_e.score);
        end
        busy = 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    game_state_t b;
    repeat (3) @(negedge game_clk);
    check_reset_values();
    reset = 1'b0;

    b = with_row(blank_game_state, 19, 10'h3FF);
    b = with_row(b, 18, 10'h008);
    issue(b);
    wait_done();

    b = blank_game_state;
    for (int rr = 16; rr < 20; rr++) b = with_row(b, rr, 10'h3FF);
    issue(b);
    wait_done();

    b = with_row(blank_game_state, 19, 10'h3FF);
    b = with_row(b, 18, 10'h155);
    b = with_row(b, 17, 10'h3FF);
    b = with_row(b, 16, 10'h0AA);
    issue(b);
    wait_done();

    b = with_row(blank_game_state, 19, 10'h1FF);
    b = with_row(b, 10, 10'h3FE);
    issue(b);
    wait_done();

    b = blank_game_state;
    for (int rr = 0; rr < ROWS; rr++) b = with_row(b, rr, 10'h3FF);
    issue(b);
    wait_done();

    b = with_row(blank_game_state, 0, 10'h3FF);
    issue(b);
    wait_done();

    for (int n = 0; n < 16; n++) begin
      issue(rand_board());
      wait_done();
    end

    check("lock_dropped_clear", lock_dropped, 0);
    b = with_row(blank_game_state, 19, 10'h3FF);
    b = with_row(b, 18, 10'h020);
    issue(b);
    repeat (4) @(negedge game_clk);
    board_in   = rand_board();
    lock_valid = 1'b1;
    @(negedge game_clk);
    lock_valid = 1'b0;
    wait_done();
    repeat (5) @(negedge game_clk);
    check("lock_dropped_set", lock_dropped, 1);

    b = blank_game_state;
    for (int rr = 16; rr < 20; rr++) b = with_row(b, rr, 10'h3FF);
    issue(b);
    @(negedge game_clk);
    reset = 1'b1;
    sb.delete();
    m_lines = '0;
    m_score = '0;
    @(negedge game_clk);
    check_reset_values();
    reset = 1'b0;
    repeat (30) @(negedge game_clk);
    check("post_reset_idle", clearing_line, 0);

    b = with_row(blank_game_state, 19, 10'h3FF);
    b = with_row(b, 18, 10'h008);
    issue(b);
    wait_done();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
